// File: rtl/vga_pkg.sv
// Shared timing constants for the vga pixel bus: default 800x600 @ 60 Hz
// (40 MHz pixel clock) and the counter width used by every bus consumer.
package vga_pkg;

  localparam int CNT_W = 11;

  localparam int HOR_PIXELS     = 800;
  localparam int HOR_TOTAL      = 1056;
  localparam int HOR_SYNC_START = 840;
  localparam int HOR_SYNC_WIDTH = 128;

  localparam int VER_PIXELS     = 600;
  localparam int VER_TOTAL      = 628;
  localparam int VER_SYNC_START = 601;
  localparam int VER_SYNC_WIDTH = 4;

endpackage

// File: rtl/vga_if.sv
// Pixel bus passed down the draw pipeline: counters, active-high syncs,
// blanking flags and colour. The timing generator drives it through 'out'.
interface vga_if;
  import vga_pkg::*;

  logic [CNT_W-1:0] hcount;
  logic [CNT_W-1:0] vcount;
  logic             hsync;
  logic             vsync;
  logic             hblnk;
  logic             vblnk;
  logic [11:0]      rgb;

  modport out    (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport in     (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_counter.sv
// Modulo-N counter with enable. 'wrap' flags the enabled edge that returns
// the count to zero; 'count_next' exposes the value the next edge will load.
module vga_counter
  import vga_pkg::*;
#(
  parameter int N = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_next,
  output logic             wrap
);

  always_comb begin
    wrap       = en && (count == CNT_W'(N - 1));
    count_next = count;
    if (wrap)
      count_next = '0;
    else if (en)
      count_next = count + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else
      count <= count_next;
  end

endmodule

// File: rtl/vga_timing.sv
// VGA timing generator at the head of the draw pipeline. Optional macro
// VGA_TIMING_FRAME_START_EN adds a one-cycle frame_start pulse on each frame wrap.
module vga_timing #(
  parameter int HOR_PIXELS     = vga_pkg::HOR_PIXELS,
  parameter int HOR_TOTAL      = vga_pkg::HOR_TOTAL,
  parameter int HOR_SYNC_START = vga_pkg::HOR_SYNC_START,
  parameter int HOR_SYNC_WIDTH = vga_pkg::HOR_SYNC_WIDTH,
  parameter int VER_PIXELS     = vga_pkg::VER_PIXELS,
  parameter int VER_TOTAL      = vga_pkg::VER_TOTAL,
  parameter int VER_SYNC_START = vga_pkg::VER_SYNC_START,
  parameter int VER_SYNC_WIDTH = vga_pkg::VER_SYNC_WIDTH
) (
  input  logic clk,
  input  logic rst,
  vga_if.out   vga_out
`ifdef VGA_TIMING_FRAME_START_EN
  ,
  output logic frame_start
`endif
);
  import vga_pkg::*;

  // Timings must fit the 11-bit counters and keep each sync inside its period.
  if (HOR_TOTAL > 2048 || VER_TOTAL > 2048 ||
      HOR_SYNC_START + HOR_SYNC_WIDTH > HOR_TOTAL ||
      VER_SYNC_START + VER_SYNC_WIDTH > VER_TOTAL) begin : g_bad_params
    $error("vga_timing: timing parameters out of range");
  end

  logic [CNT_W-1:0] h_count, h_next;
  logic [CNT_W-1:0] v_count, v_next;
  logic             h_wrap, v_wrap;
  logic             hsync_q, vsync_q, hblnk_q, vblnk_q;

  vga_counter #(.N(HOR_TOTAL)) u_hcnt (
    .clk        (clk),
    .rst        (rst),
    .en         (1'b1),
    .count      (h_count),
    .count_next (h_next),
    .wrap       (h_wrap)
  );

  vga_counter #(.N(VER_TOTAL)) u_vcnt (
    .clk        (clk),
    .rst        (rst),
    .en         (h_wrap),
    .count      (v_count),
    .count_next (v_next),
    .wrap       (v_wrap)
  );

  // Flags are decoded from the counts about to be loaded, so after the edge
  // each flag describes the very hcount/vcount pair it travels with.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
      hblnk_q <= 1'b0;
      vblnk_q <= 1'b0;
    end else begin
      hblnk_q <= int'(h_next) >= HOR_PIXELS;
      vblnk_q <= int'(v_next) >= VER_PIXELS;
      hsync_q <= (int'(h_next) >= HOR_SYNC_START) &&
                 (int'(h_next) <  HOR_SYNC_START + HOR_SYNC_WIDTH);
      vsync_q <= (int'(v_next) >= VER_SYNC_START) &&
                 (int'(v_next) <  VER_SYNC_START + VER_SYNC_WIDTH);
    end
  end

  assign vga_out.hcount = h_count;
  assign vga_out.vcount = v_count;
  assign vga_out.hsync  = hsync_q;
  assign vga_out.vsync  = vsync_q;
  assign vga_out.hblnk  = hblnk_q;
  assign vga_out.vblnk  = vblnk_q;
  assign vga_out.rgb    = 12'h000;

`ifdef VGA_TIMING_FRAME_START_EN
  // Only a real wrap pulses; the reset state itself never does.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      frame_start <= 1'b0;
    else
      frame_start <= h_wrap && v_wrap;
  end
`else
  logic unused_v_wrap;
  assign unused_v_wrap = v_wrap;
`endif

endmodule

// File: doc/vga_timing.md
Name: vga_timing

Overview:
- Source end of the vga_if pixel bus. It generates hcount/vcount, sync and blanking for every downstream draw stage; draw stages consume and re-register these signals.
- Free-running from reset, with no input handshake.
- Default mode is 800x600 @ 60 Hz with a 40 MHz pixel clock.
- Instantiated once at the head of the draw pipeline.

Parameters:
- HOR_PIXELS, 800: active pixels per line.
- HOR_TOTAL, 1056: clocks per line (active plus blanking).
- HOR_SYNC_START, 840: first hcount with hsync asserted.
- HOR_SYNC_WIDTH, 128: hsync length in clocks.
- VER_PIXELS, 600: active lines per frame.
- VER_TOTAL, 628: lines per frame.
- VER_SYNC_START, 601: first vcount with vsync asserted.
- VER_SYNC_WIDTH, 4: vsync length in lines.

Ports:
- clk, input, 1: pixel clock.
- rst, input, 1: asynchronous, active-high reset.
- vga_out, vga_if.out modport, interface: carries hcount[10:0], vcount[10:0], hsync, vsync, hblnk, vblnk and rgb[11:0].
- frame_start, output, 1: present only with VGA_TIMING_FRAME_START_EN.

Behaviour:
- Reset (asynchronous):
  - hcount = 0, vcount = 0.
  - hsync, vsync, hblnk, vblnk = 0.
  - rgb = 12'h000.
  - Reset mid-line or mid-frame takes effect immediately, with no completion of the current line.
- Counters:
  - hcount increments by 1 on every clk edge.
  - When hcount == HOR_TOTAL-1, hcount wraps to 0 on the next edge.
  - vcount increments only on the hcount wrap edge.
  - When vcount == VER_TOTAL-1 on an hcount wrap, vcount wraps to 0.
  - Simultaneous wrap: the edge after (HOR_TOTAL-1, VER_TOTAL-1) yields (0, 0).
- Registered outputs:
  - All outputs are registered and computed from the next-state counters, so in any cycle every flag describes the hcount/vcount pair shown in that same cycle.
  - Latency from counter to flag is zero.
- Flag rules, evaluated on the presented counts:
  - hblnk = (hcount >= HOR_PIXELS).
  - vblnk = (vcount >= VER_PIXELS).
  - hsync = (hcount >= HOR_SYNC_START) && (hcount < HOR_SYNC_START+HOR_SYNC_WIDTH).
  - vsync = (vcount >= VER_SYNC_START) && (vcount < VER_SYNC_START+VER_SYNC_WIDTH).
  - Syncs are active-high on the bus; any polarity inversion is done at the top-level pins.
- vsync runs on whole lines: it rises and falls together with an hcount wrap, never mid-line.
- rgb is held at 12'h000 permanently; draw stages overwrite it.
- The reset state (0,0 with all flags 0) is a legal first pixel: the first post-reset edge presents (1,0).
- Width rule: the counters are 11 bits. Parameter values must satisfy the following, which is elaborated as a static check that fails on violation:
  - HOR_TOTAL <= 2048 and VER_TOTAL <= 2048.
  - HOR_SYNC_START+HOR_SYNC_WIDTH <= HOR_TOTAL.
  - VER_SYNC_START+VER_SYNC_WIDTH <= VER_TOTAL.

Optional Feature:
- Macro: VGA_TIMING_FRAME_START_EN.
- With the macro defined:
  - Adds the frame_start output, registered.
  - High for exactly one cycle, the cycle in which the bus presents hcount=0, vcount=0 as a result of a counter wrap.
  - Reset value is 0, and it is not asserted for the reset state itself. The first pulse occurs one full frame after reset release.
- Without the macro: the port and its logic are absent, and the bus behaviour is identical.

Decomposition:
- vga_pkg holds:
  - The default timing localparams: HOR_PIXELS, HOR_TOTAL, sync start/width, and the VER_* equivalents.
  - The counter width constant CNT_W = 11.
  - The module parameters default to these package constants.
- Sub-module vga_counter provides one modulo-N counter with:
  - an enable input;
  - parameter N;
  - a synchronous wrap-strobe output, asserted when count == N-1 && en;
  - asynchronous, active-high reset.
- vga_timing instantiates vga_counter twice: the horizontal counter with en=1, and the vertical counter with en tied to the horizontal wrap strobe.

Test Plan:
- Reset release: assert rst mid-run, check all outputs are 0 within the same cycle; release it, then check the first edge gives hcount=1, vcount=0 with all flags 0.
- Line boundaries:
  - hblnk rises at hcount=800.
  - hsync is high for exactly hcount 840..967, i.e. 128 cycles.
  - At hcount=1055 the next edge gives hcount=0 and vcount+1.
- Frame boundaries:
  - vblnk is high for vcount 600..627.
  - vsync is high for vcount 601..604, asserted for exactly 4*1056 = 4224 clocks, with edges coinciding with hcount=0.
- Frame wrap: from (1055, 627) the next edge gives (0, 0), with vblnk and hblnk both 0; the frame period measures 1056*628 = 663168 clocks.
- Reset mid-frame: assert rst at (412, 300), check an immediate return to 0, then normal counting resumes after release.
- Feature VGA_TIMING_FRAME_START_EN:
  - frame_start pulses once per 663168 clocks, aligned to (0, 0).
  - No pulse in the first frame after reset.
  - A build without the macro produces bus traces identical to a build with it.
